mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arb_grant.sv | 25 ++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state encoding and grant encoding for the instruction/data memory arbiter.
// Round-robin arbitration is enabled with `define MEM_ARB_RR_EN; otherwise data has fixed priority.
package mem_arbiter_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;
  localparam int WE_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_e;

  function automatic gnt_e other_port(input gnt_e g);
    return (g == GNT_INST) ? GNT_DATA : GNT_INST;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, load/store port and shared bus channel of the memory arbiter.
// master is the arbiter's view; slave is the core/memory side that drives it.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = mem_arbiter_pkg::ADDR_BUS,
    parameter int DATA_WIDTH = mem_arbiter_pkg::DATA_BUS
) ();
    import mem_arbiter_pkg::*;

    logic                  inst_req;
    logic [ADDR_WIDTH-1:0] inst_addr;
    logic [DATA_WIDTH-1:0] inst_rdata;
    logic                  inst_ready;

    logic                  data_req;
    logic [WE_W-1:0]       data_we;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [DATA_WIDTH-1:0] data_wdata;
    logic [DATA_WIDTH-1:0] data_rdata;
    logic                  data_ready;

    logic                  bus_req;
    logic [WE_W-1:0]       bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_addr_ok;
    logic                  bus_data_ok;
    logic [DATA_WIDTH-1:0] bus_rdata;

    logic                  stall_if;
    logic                  stall_mem;

    modport master (
        input  inst_req, inst_addr,
        output inst_rdata, inst_ready,
        input  data_req, data_we, data_addr, data_wdata,
        output data_rdata, data_ready,
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output stall_if, stall_mem
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_rdata, inst_ready,
        output data_req, data_we, data_addr, data_wdata,
        input  data_rdata, data_ready,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/mem_arb_grant.sv
// Grant selection between the fetch and load/store ports.
// With MEM_ARB_RR_EN a tie goes to the port not granted last; otherwise data always wins.
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
`ifdef MEM_ARB_RR_EN
    input  gnt_e last_grant,
`endif
    output logic any_req,
    output gnt_e grant
);

    assign any_req = inst_req | data_req;

    always_comb begin
        grant = data_req ? GNT_DATA : GNT_INST;
`ifdef MEM_ARB_RR_EN
        if (inst_req && data_req)
            grant = other_port(last_grant);
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter onto a single split address/data memory bus.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build uses fixed data-over-inst priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_BUS,
    parameter int DATA_WIDTH = DATA_BUS
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    arb_state_e state_q, state_d;
    gnt_e       owner_q;
    gnt_e       grant;
    logic       any_req;
    logic       grant_en;

    logic [WE_W-1:0]       we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] inst_rdata_q;
    logic [DATA_WIDTH-1:0] data_rdata_q;

    assign grant_en = (state_q == S_IDLE) && any_req;

`ifdef MEM_ARB_RR_EN
    gnt_e last_q;

    mem_arb_grant u_grant (
        .inst_req   (bus.inst_req),
        .data_req   (bus.data_req),
        .last_grant (last_q),
        .any_req    (any_req),
        .grant      (grant)
    );

    // Reset leaves "inst granted last", so the first tie goes to data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_q <= GNT_INST;
        else if (grant_en)
            last_q <= grant;
    end
`else
    mem_arb_grant u_grant (
        .inst_req (bus.inst_req),
        .data_req (bus.data_req),
        .any_req  (any_req),
        .grant    (grant)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.bus_req    = 1'b0;
        bus.inst_ready = 1'b0;
        bus.data_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req)
                    state_d = S_REQ;
            end
            S_REQ: begin
                // data_ok is deliberately not looked at until the address phase is accepted
                bus.bus_req = 1'b1;
                if (bus.bus_addr_ok)
                    state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.bus_data_ok)
                    state_d = S_DONE;
            end
            S_DONE: begin
                bus.inst_ready = (owner_q == GNT_INST);
                bus.data_ready = (owner_q == GNT_DATA);
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are captured once at grant so the requester may change them mid-flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= GNT_INST;
            we_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            if (grant_en) begin
                owner_q <= grant;
                if (grant == GNT_DATA) begin
                    we_q    <= bus.data_we;
                    addr_q  <= bus.data_addr;
                    wdata_q <= bus.data_wdata;
                end else begin
                    we_q    <= '0;
                    addr_q  <= bus.inst_addr;
                    wdata_q <= '0;
                end
            end
            // Stores complete without touching the owner's read data.
            if (state_q == S_RESP && bus.bus_data_ok && we_q == '0) begin
                if (owner_q == GNT_DATA)
                    data_rdata_q <= bus.bus_rdata;
                else
                    inst_rdata_q <= bus.bus_rdata;
            end
        end
    end

    assign bus.bus_we     = we_q;
    assign bus.bus_addr   = addr_q;
    assign bus.bus_wdata  = wdata_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.data_rdata = data_rdata_q;

    assign bus.stall_if   = bus.inst_req & ~bus.inst_ready;
    assign bus.stall_mem  = bus.data_req & ~bus.data_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scripted bus responder, transaction-timing reference model
// checked every cycle, plus literal expectations for the key scenarios (honours MEM_ARB_RR_EN).
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Bus responder knobs: accept address after addr_wait cycles of bus_req, data after data_wait more.
    int          addr_wait = 0;
    int          data_wait = 0;
    bit          spur      = 1'b0;
    logic [31:0] rd_val    = '0;

    int          rcnt = 0;
    int          dcnt = 0;
    bit          pend = 1'b0;
    logic [31:0] resp_addr = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt <= 0;
            dcnt <= 0;
            pend <= 1'b0;
        end else begin
            if (bif.bus_req && !bif.bus_addr_ok) rcnt <= rcnt + 1;
            else                                 rcnt <= 0;
            if (bif.bus_req && bif.bus_addr_ok) begin
                pend      <= 1'b1;
                dcnt      <= 0;
                resp_addr <= bif.bus_addr;
            end else if (pend) begin
                if (bif.bus_data_ok) pend <= 1'b0;
                else                 dcnt <= dcnt + 1;
            end
        end
    end

    assign bif.bus_addr_ok = bif.bus_req && (rcnt == addr_wait);
    assign bif.bus_data_ok = (pend && dcnt == data_wait) || (spur && bif.bus_req);
    assign bif.bus_rdata   = rd_val ^ resp_addr;

    // Reference model: a granted transaction occupies a fixed window of cycles derived from the waits.
    int          now = 0;
    bit          m_busy = 1'b0;
    bit          m_own_d = 1'b0;
    bit          m_last_d = 1'b0;
    int          m_g = 0, m_aw = 0, m_dw = 0;
    logic [3:0]  m_we = '0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_ird = '0, m_drd = '0;

    function automatic bit model_pick(input bit i, input bit d, input bit last_d);
        bit rr;
        rr = 1'b0;
`ifdef MEM_ARB_RR_EN
        rr = 1'b1;
`endif
        return (rr && i && d) ? !last_d : d;
    endfunction

    bit m_pick;
    assign m_pick = model_pick(bif.inst_req, bif.data_req, m_last_d);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy   <= 1'b0;
            m_ird    <= '0;
            m_drd    <= '0;
            m_last_d <= 1'b0;
        end else begin
            now <= now + 1;
            if (!m_busy) begin
                if (bif.inst_req || bif.data_req) begin
                    m_busy   <= 1'b1;
                    m_g      <= now;
                    m_own_d  <= m_pick;
                    m_last_d <= m_pick;
                    m_we     <= m_pick ? bif.data_we    : 4'h0;
                    m_addr   <= m_pick ? bif.data_addr  : bif.inst_addr;
                    m_wdata  <= m_pick ? bif.data_wdata : 32'h0;
                    m_aw     <= addr_wait;
                    m_dw     <= data_wait;
                end
            end else begin
                if (now == m_g + 2 + m_aw + m_dw && m_we == 4'h0) begin
                    if (m_own_d) m_drd <= rd_val ^ m_addr;
                    else         m_ird <= rd_val ^ m_addr;
                end
                if (now == m_g + 3 + m_aw + m_dw)
                    m_busy <= 1'b0;
            end
        end
    end

    bit e_bus, e_iready, e_dready;
    assign e_bus    = m_busy && now >= m_g + 1 && now <= m_g + 1 + m_aw;
    assign e_iready = m_busy && !m_own_d && now == m_g + 3 + m_aw + m_dw;
    assign e_dready = m_busy &&  m_own_d && now == m_g + 3 + m_aw + m_dw;

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_bus_req", bif.bus_req, e_bus);
            if (e_bus) begin
                chk("cyc_bus_we",    bif.bus_we,    m_we);
                chk("cyc_bus_addr",  bif.bus_addr,  m_addr);
                chk("cyc_bus_wdata", bif.bus_wdata, m_wdata);
            end
            chk("cyc_inst_ready", bif.inst_ready, e_iready);
            chk("cyc_data_ready", bif.data_ready, e_dready);
            chk("cyc_inst_rdata", bif.inst_rdata, m_ird);
            chk("cyc_data_rdata", bif.data_rdata, m_drd);
            chk("cyc_stall_if",   bif.stall_if,  bif.inst_req & ~e_iready);
            chk("cyc_stall_mem",  bif.stall_mem, bif.data_req & ~e_dready);
        end
    end

    // Waits for the wanted ready pulses, dropping each request after its pulse.
    // mode 1 scrambles request fields after grant; mode 2 drops the requests after grant.
    task automatic wait_done(input bit wi, input bit wd, input int mode,
                             output int ti, output int td, output int nb, output int ns,
                             output logic [31:0] ca, output logic [31:0] cw, output logic [3:0] ce);
        bit gi, gd;
        int n;
        gi = !wi; gd = !wd; n = 0;
        ti = -1; td = -1; nb = 0; ns = 0; ca = '0; cw = '0; ce = '0;
        while (!(gi && gd) && n < 40) begin
            @(negedge clk);
            if (bif.bus_req === 1'b1) begin
                nb++;
                ca = bif.bus_addr; cw = bif.bus_wdata; ce = bif.bus_we;
            end
            if (bif.stall_if === 1'b1) ns++;
            if (wi && !gi && bif.inst_ready === 1'b1) begin gi = 1'b1; ti = now; end
            if (wd && !gd && bif.data_ready === 1'b1) begin gd = 1'b1; td = now; end
            @(posedge clk); #1;
            if (wi && gi) bif.inst_req = 1'b0;
            if (wd && gd) bif.data_req = 1'b0;
            if (n == 0 && mode == 1) begin
                bif.inst_addr  = 32'hFFFF_0000;
                bif.data_addr  = 32'h1234_5678;
                bif.data_wdata = 32'h0BAD_F00D;
                bif.data_we    = 4'h0;
            end
            if (n == 0 && mode == 2) begin
                bif.inst_req = 1'b0;
                bif.data_req = 1'b0;
            end
            n++;
        end
        chk("completed", {62'd0, gi, gd}, 64'd3);
    endtask

    int          t0, ti, td, nb, ns, ti1, nrdy;
    logic [31:0] ca, cw;
    logic [3:0]  ce;

    initial begin
        bif.inst_req = 1'b0; bif.inst_addr = '0;
        bif.data_req = 1'b0; bif.data_we = '0; bif.data_addr = '0; bif.data_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req",    bif.bus_req, 0);
        chk("rst_bus_addr",   bif.bus_addr, 0);
        chk("rst_readies",    {bif.inst_ready, bif.data_ready}, 0);
        chk("rst_inst_rdata", bif.inst_rdata, 0);
        chk("rst_data_rdata", bif.data_rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;

        // Lone fetch, zero-wait bus
        addr_wait = 0; data_wait = 0; rd_val = 32'h2408_0001 ^ 32'hBFC0_0000;
        @(posedge clk); #1;
        bif.inst_req = 1'b1; bif.inst_addr = 32'hBFC0_0000; t0 = now;
        wait_done(1, 0, 0, ti, td, nb, ns, ca, cw, ce);
        chk("fetch_latency",  ti - t0, 3);
        chk("fetch_rdata",    bif.inst_rdata, 32'h2408_0001);
        chk("fetch_stall_n",  ns, 3);
        chk("fetch_bus_n",    nb, 1);

        // Store, address phase accepted after 2 waits, spurious data_ok during REQ, fields scrambled
        addr_wait = 2; spur = 1'b1; rd_val = 32'h1357_9BDF;
        @(posedge clk); #1;
        bif.data_req = 1'b1; bif.data_we = 4'hF; bif.data_addr = 32'h8000_0010;
        bif.data_wdata = 32'hDEAD_BEEF; t0 = now;
        wait_done(0, 1, 1, ti, td, nb, ns, ca, cw, ce);
        spur = 1'b0;
        chk("store_latency",  td - t0, 5);
        chk("store_bus_n",    nb, 3);
        chk("store_bus_addr", ca, 32'h8000_0010);
        chk("store_bus_data", cw, 32'hDEAD_BEEF);
        chk("store_bus_we",   ce, 4'hF);
        chk("store_rdata",    bif.data_rdata, 0);

        // Simultaneous loads right after a data grant
        addr_wait = 0; rd_val = 32'h0F0F_0000;
        @(posedge clk); #1;
        bif.inst_req = 1'b1; bif.inst_addr = 32'h0000_1000;
        bif.data_req = 1'b1; bif.data_we = 4'h0; bif.data_addr = 32'h0000_2000; t0 = now;
        wait_done(1, 1, 0, ti, td, nb, ns, ca, cw, ce);
`ifdef MEM_ARB_RR_EN
        chk("tie1_inst_lat", ti - t0, 3);
        chk("tie1_data_lat", td - t0, 7);
`else
        chk("tie1_data_lat", td - t0, 3);
        chk("tie1_inst_lat", ti - t0, 7);
`endif
        chk("tie1_inst_rdata", bif.inst_rdata, 32'h0F0F_1000);
        chk("tie1_data_rdata", bif.data_rdata, 32'h0F0F_2000);

        // Fetch alone, then a tie: data wins under either policy
        @(posedge clk); #1;
        bif.inst_req = 1'b1; bif.inst_addr = 32'h0000_1100;
        wait_done(1, 0, 0, ti, td, nb, ns, ca, cw, ce);
        bif.inst_req = 1'b1; bif.inst_addr = 32'h0000_1200;
        bif.data_req = 1'b1; bif.data_addr = 32'h0000_2200; t0 = now;
        wait_done(1, 1, 0, ti, td, nb, ns, ca, cw, ce);
        chk("tie2_data_lat", td - t0, 3);
        chk("tie2_inst_lat", ti - t0, 7);

        // Back-to-back fetches
        rd_val = 32'h5555_0000;
        @(posedge clk); #1;
        bif.inst_req = 1'b1; bif.inst_addr = 32'h0000_3000;
        wait_done(1, 0, 0, ti1, td, nb, ns, ca, cw, ce);
        chk("b2b_bus_n1", nb, 1);
        bif.inst_req = 1'b1; bif.inst_addr = 32'h0000_3004;
        wait_done(1, 0, 0, ti, td, nb, ns, ca, cw, ce);
        chk("b2b_gap",     ti - ti1, 4);
        chk("b2b_bus_n2",  nb, 1);
        chk("b2b_rdata",   bif.inst_rdata, 32'h5555_3004);

        // Request withdrawn after grant still completes
        addr_wait = 1; data_wait = 1; rd_val = 32'hAAAA_0000;
        @(posedge clk); #1;
        bif.data_req = 1'b1; bif.data_we = 4'h0; bif.data_addr = 32'h0000_4000; t0 = now;
        wait_done(0, 1, 2, ti, td, nb, ns, ca, cw, ce);
        chk("drop_latency", td - t0, 5);
        chk("drop_rdata",   bif.data_rdata, 32'hAAAA_4000);

        // Reset while waiting for data
        addr_wait = 0; data_wait = 3;
        @(posedge clk); #1;
        bif.inst_req = 1'b1; bif.inst_addr = 32'h0000_5000;
        repeat (3) begin @(posedge clk); #1; end
        bif.inst_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstmid_bus_req", bif.bus_req, 0);
        chk("rstmid_readies", {bif.inst_ready, bif.data_ready}, 0);
        chk("rstmid_rdata",   {bif.inst_rdata, bif.data_rdata}, 0);
        chk("rstmid_stall",   {bif.stall_if, bif.stall_mem}, 0);
        @(negedge clk);
        rst = 1'b1;
        nrdy = 0;
        repeat (8) begin
            @(negedge clk);
            if (bif.inst_ready !== 1'b0 || bif.data_ready !== 1'b0) nrdy++;
        end
        chk("rstmid_no_ready", nrdy, 0);
        data_wait = 0; rd_val = 32'h7777_0000;
        @(posedge clk); #1;
        bif.inst_req = 1'b1; bif.inst_addr = 32'h0000_6000; t0 = now;
        wait_done(1, 0, 0, ti, td, nb, ns, ca, cw, ce);
        chk("post_rst_latency", ti - t0, 3);
        chk("post_rst_rdata",   bif.inst_rdata, 32'h7777_6000);

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
